alu2_exec: RTL and testbench
============================

ALU2_EXEC -- requirements
Module: alu2_exec

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: start  input  1  request to execute; accepted only when busy=0.
REQ-004 SHALL: ALUcontrol  input  3  op select: 000 mfc1, 001 mtc1, 010 add.s, 011 sub.s, 100 mov.s, 101 c.eq.s, 110 c.lt.s, 111 c.le.s.
REQ-005 SHALL: a  input  32  operand A: source for move ops, first operand otherwise.
REQ-006 SHALL: b  input  32  operand B: second operand for add/sub/compare.
REQ-007 SHALL: busy  output  1  high while a multi-cycle op is in flight.
REQ-008 SHALL: done  output  1  one-cycle pulse; result/cc valid that cycle and held until the next done.
REQ-009 SHALL: result  output  32  registered result.
REQ-010 SHALL: cc  output  1  FP condition flag; written only by compare ops.

Function
REQ-011 SHALL: FSM states IDLE, ALIGN, ADD, NORM; ALUcontrol, a and b are captured on the accepting edge.
REQ-012 SHALL: start is accepted when state=IDLE; start while busy=1 is ignored with no side effect.
REQ-013 SHALL: move/compare ops (000,001,100,101,110,111) complete with done at cycle N+1 for start at N, FSM staying in IDLE and busy staying 0.
REQ-014 SHALL: add.s/sub.s traverse IDLE->ALIGN(N+1)->ADD(N+2)->NORM(N+3)->IDLE, done=1 at N+4, busy=1 during N+1..N+3.
REQ-015 SHALL: done cycle is IDLE, so a start in the done cycle is accepted (back-to-back, no bubble).
REQ-016 SHALL: mfc1, mtc1, mov.s give result=a bit-exact (NaN payload kept); cc unchanged.
REQ-017 SHALL: compares give result=32'h0000_0001 if true else 32'h0, and cc=same bit.
REQ-018 SHALL: compares treat +0 and -0 as equal; any NaN operand makes the compare false.
REQ-019 SHALL: sub.s is add.s with the sign of b inverted.
REQ-020 SHALL: in ALIGN, shift the smaller-exponent mantissa (hidden bit restored) right by the exponent difference, saturating at 26, with shifted-out bits ORed into a sticky bit.
REQ-021 SHALL: in ADD, perform a 25-bit signed-magnitude add/subtract, larger magnitude first, with the result sign taken from the larger operand.
REQ-022 SHALL: in NORM, normalise with a single-cycle leading-zero count and shift, then adjust the exponent.
REQ-023 SHALL: exponent field 0 inputs are flushed to +0 (denormals unsupported); an underflowing result yields +0.
REQ-024 SHALL: exponent overflow yields signed infinity (0x7F800000 / 0xFF800000).
REQ-025 SHALL: any NaN input, or inf-inf, yields 0x7FC00000; inf plus finite yields that inf.
REQ-026 SHALL: exact cancellation yields +0 (0x00000000).

Reset
REQ-027 SHALL: rst forces state=IDLE, busy=0, done=0, result=0, cc=0 on the next edge.
REQ-028 SHALL: rst mid-operation abandons the op; no done is produced for it.
REQ-029 SHALL: start is ignored in any cycle where rst=1.

Configuration
REQ-030 SHALL: with ALU2_ROUND_NEAREST_EN defined, add/sub results round to nearest-even using guard, round and sticky bits in NORM, with the mantissa carry-out renormalising within NORM.
REQ-031 SHALL: without ALU2_ROUND_NEAREST_EN, add/sub results truncate (round toward zero); latency is identical in both builds.

Verification
REQ-032 SHALL: add.s a=0x3F800000, b=0x40000000, start at N -> done at N+4, result=0x40400000, busy high N+1..N+3.
REQ-033 SHALL: sub.s a=b=0x3FC00000 -> result=0x00000000; add.s a=b=0x7F7FFFFF -> result=0x7F800000.
REQ-034 SHALL: c.lt.s a=0x3F800000, b=0x40000000 -> done at N+1, cc=1, result=1; c.eq.s a=0x7FC00000, b=0x7FC00000 -> cc=0.
REQ-035 SHALL: add.s a=0x3F800000, b=0x33C00000 -> result=0x3F800001 with ALU2_ROUND_NEAREST_EN, 0x3F800000 without.
REQ-036 SHALL: start with a new op during busy -> ignored, the original result is delivered unchanged at N+4.
REQ-037 SHALL: rst at N+2 of an add.s -> done stays 0, outputs are 0, and a new mov.s a=0xDEADBEEF gives result=0xDEADBEEF one cycle after start.

Source files
------------

// File: rtl/alu2_exec_if.sv
// ---------------------------------------------------------------------------
// alu2_exec_if -- request/response bundle for the alu2_exec FP execute unit.
//
// Signals
//   start       request to execute (accepted only while busy is low)
//   ALUcontrol  op select: 000 mfc1, 001 mtc1, 010 add.s, 011 sub.s,
//               100 mov.s, 101 c.eq.s, 110 c.lt.s, 111 c.le.s
//   a, b        32-bit operands
//   busy        a multi-cycle add/sub is in flight
//   done        one-cycle completion pulse
//   result      registered 32-bit result, held until the next done
//   cc          FP condition flag, written only by compares
//
// Modports
//   master  requester side (drives start/op/operands)
//   slave   execute-unit side (drives busy/done/result/cc)
// ---------------------------------------------------------------------------
interface alu2_exec_if;
    logic        start;
    logic [2:0]  ALUcontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        cc;

    modport master (
        output start, ALUcontrol, a, b,
        input  busy, done, result, cc
    );

    modport slave (
        input  start, ALUcontrol, a, b,
        output busy, done, result, cc
    );
endinterface

// File: rtl/alu2_exec.sv
// ---------------------------------------------------------------------------
// alu2_exec -- single-precision FP execute unit (moves, compares, add/sub).
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   alu2_exec_if.slave: start, ALUcontrol, a, b in;
//         busy, done, result, cc out
//
// Moves and compares finish one cycle after acceptance without leaving IDLE.
// add.s / sub.s walk IDLE -> ALIGN -> ADD -> NORM -> IDLE and pulse done on
// the cycle they return to IDLE, so a new start can be taken in that cycle.
// Denormal inputs are flushed to zero; underflow gives +0.
//
// Build option
//   ALU2_ROUND_NEAREST_EN  defined: add/sub round to nearest-even using
//                          guard/round/sticky; undefined: truncate.
// ---------------------------------------------------------------------------
module alu2_exec (
    input  logic       clk,
    input  logic       rst,
    alu2_exec_if.slave bus
);
    localparam logic [2:0]  OP_ADD = 3'b010;
    localparam logic [2:0]  OP_SUB = 3'b011;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

    state_t      state;
    logic        busy_r, done_r, cc_r;
    logic [31:0] result_r;

    // Compare via a signed key: flushed zeros map to 0 so +0 == -0,
    // negative values are negated magnitudes. NaN forces false.
    function automatic logic fp_cmp(input logic [2:0] op, input logic [31:0] x,
                                    input logic [31:0] y);
        logic signed [32:0] kx, ky;
        logic               nan;
        nan = ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) ||
              ((y[30:23] == 8'hFF) && (y[22:0] != 23'd0));
        kx  = (x[30:23] == 8'd0) ? 33'sd0 :
              (x[31] ? -$signed({2'b00, x[30:0]}) : $signed({2'b00, x[30:0]}));
        ky  = (y[30:23] == 8'd0) ? 33'sd0 :
              (y[31] ? -$signed({2'b00, y[30:0]}) : $signed({2'b00, y[30:0]}));
        case (op)
            3'b101:  fp_cmp = !nan && (kx == ky);
            3'b110:  fp_cmp = !nan && (kx < ky);
            3'b111:  fp_cmp = !nan && (kx <= ky);
            default: fp_cmp = 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i <= 26; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    // n = {mantissa[23:0], guard, round, sticky}; bit 24 of the return value
    // is the mantissa carry-out.
    function automatic logic [24:0] round_mant(input logic [26:0] n);
`ifdef ALU2_ROUND_NEAREST_EN
        round_mant = {1'b0, n[26:3]} + 25'(n[2] & (n[1] | n[0] | n[3]));
`else
        round_mant = 25'(n >> 3);
`endif
    endfunction

    logic        sub_p0;
    logic [31:0] a_p0, b_p0;

    logic              spec_p1, sign_p1, eff_sub_p1;
    logic [31:0]       spec_val_p1;
    logic signed [9:0] exp_p1;
    logic [26:0]       mx_p1, my_p1;

    logic              spec_p2, sign_p2;
    logic [31:0]       spec_val_p2;
    logic signed [9:0] exp_p2;
    logic [27:0]       sum_p2;

    logic        al_spec, al_sign, al_eff_sub;
    logic [31:0] al_spec_val;
    logic [7:0]  al_exp;
    logic [26:0] al_mx, al_my;
    logic [27:0] add_sum;
    logic [31:0] norm_res;
    logic        cmp_res;

    assign cmp_res = fp_cmp(bus.ALUcontrol, bus.a, bus.b);

    // Operands are ordered by magnitude so the subtraction in ADD never goes
    // negative; the smaller one is aligned with a sticky bit.
    always_comb begin : align_c
        logic [7:0]  ea, eb, ex, ey, d;
        logic [23:0] ma, mb, mx, my;
        logic        sa, sb, sy, a_nan, b_nan, a_inf, b_inf, a_big;
        logic [51:0] sh_y;
        ea    = a_p0[30:23];
        eb    = b_p0[30:23];
        ma    = (ea == 8'd0) ? 24'd0 : {1'b1, a_p0[22:0]};
        mb    = (eb == 8'd0) ? 24'd0 : {1'b1, b_p0[22:0]};
        sa    = a_p0[31];
        sb    = b_p0[31] ^ sub_p0;
        a_nan = (ea == 8'hFF) && (a_p0[22:0] != 23'd0);
        b_nan = (eb == 8'hFF) && (b_p0[22:0] != 23'd0);
        a_inf = (ea == 8'hFF) && (a_p0[22:0] == 23'd0);
        b_inf = (eb == 8'hFF) && (b_p0[22:0] == 23'd0);
        a_big = {ea, ma} >= {eb, mb};
        ex    = a_big ? ea : eb;
        ey    = a_big ? eb : ea;
        mx    = a_big ? ma : mb;
        my    = a_big ? mb : ma;
        sy    = a_big ? sb : sa;
        d     = ex - ey;
        sh_y  = {my, 2'b00, 26'd0} >> ((d > 8'd26) ? 8'd26 : d);
        al_sign    = a_big ? sa : sb;
        al_eff_sub = al_sign ^ sy;
        al_exp     = ex;
        al_mx      = {mx, 3'b000};
        al_my      = {sh_y[51:26], |sh_y[25:0]};
        al_spec    = a_nan | b_nan | a_inf | b_inf;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            al_spec_val = QNAN;
        else if (a_inf)
            al_spec_val = {sa, 8'hFF, 23'd0};
        else
            al_spec_val = {sb, 8'hFF, 23'd0};
    end

    assign add_sum = eff_sub_p1 ? ({1'b0, mx_p1} - {1'b0, my_p1})
                                : ({1'b0, mx_p1} + {1'b0, my_p1});

    always_comb begin : norm_c
        logic [4:0]        lz;
        logic [26:0]       n;
        logic [24:0]       rm;
        logic [22:0]       frac;
        logic signed [9:0] e;
        lz = lzc27(sum_p2[26:0]);
        if (sum_p2[27]) begin
            n = sum_p2[27:1] | {26'd0, sum_p2[0]};
            e = exp_p2 + 10'sd1;
        end else begin
            n = sum_p2[26:0] << lz;
            e = exp_p2 - $signed({5'd0, lz});
        end
        rm = round_mant(n);
        // Rounding carry leaves 1.000..0, so only the exponent moves.
        if (rm[24]) begin
            frac = rm[23:1];
            e    = e + 10'sd1;
        end else begin
            frac = rm[22:0];
        end
        if (spec_p2)
            norm_res = spec_val_p2;
        else if ((sum_p2 == 28'd0) || (e <= 10'sd0))
            norm_res = 32'd0;
        else if (e >= 10'sd255)
            norm_res = {sign_p2, 8'hFF, 23'd0};
        else
            norm_res = {sign_p2, e[7:0], frac};
    end

    always_ff @(posedge clk) begin
        // IDLE: operand capture
        if ((state == IDLE) && bus.start) begin
            a_p0   <= bus.a;
            b_p0   <= bus.b;
            sub_p0 <= (bus.ALUcontrol == OP_SUB);
        end
        // ALIGN -> ADD
        spec_p1     <= al_spec;
        spec_val_p1 <= al_spec_val;
        sign_p1     <= al_sign;
        eff_sub_p1  <= al_eff_sub;
        exp_p1      <= $signed({2'b00, al_exp});
        mx_p1       <= al_mx;
        my_p1       <= al_my;
        // ADD -> NORM
        spec_p2     <= spec_p1;
        spec_val_p2 <= spec_val_p1;
        sign_p2     <= sign_p1;
        exp_p2      <= exp_p1;
        sum_p2      <= add_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= 32'd0;
            cc_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if ((bus.ALUcontrol == OP_ADD) || (bus.ALUcontrol == OP_SUB)) begin
                            state  <= ALIGN;
                            busy_r <= 1'b1;
                        end else begin
                            done_r <= 1'b1;
                            if (bus.ALUcontrol[2] && (bus.ALUcontrol[1:0] != 2'b00)) begin
                                result_r <= {31'd0, cmp_res};
                                cc_r     <= cmp_res;
                            end else begin
                                result_r <= bus.a;
                            end
                        end
                    end
                end
                ALIGN: state <= ADD;
                ADD:   state <= NORM;
                NORM: begin
                    state    <= IDLE;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                    result_r <= norm_res;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.cc     = cc_r;
endmodule

// File: tb/tb_alu2_exec.sv
module tb_alu2_exec;
    logic clk;
    logic rst;
    alu2_exec_if bus();

    alu2_exec dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    logic cc_exp   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    // Exact sum on a wide integer grid, then normalise and round once.
    function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                            input bit sub);
        logic [319:0] vx, vy, s;
        int           ex, ey, emin, p, e;
        bit           sx, sy, sr, up;
        logic [23:0]  m;
        sx = x[31];
        sy = y[31] ^ sub;
        if (is_nan(x) || is_nan(y)) return 32'h7FC00000;
        if (is_inf(x) && is_inf(y)) return (sx != sy) ? 32'h7FC00000 : {sx, 8'hFF, 23'd0};
        if (is_inf(x)) return {sx, 8'hFF, 23'd0};
        if (is_inf(y)) return {sy, 8'hFF, 23'd0};
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        vx = (ex == 0) ? 320'd0 : 320'({1'b1, x[22:0]});
        vy = (ey == 0) ? 320'd0 : 320'({1'b1, y[22:0]});
        if (ex == 0) ex = 1;
        if (ey == 0) ey = 1;
        emin = (ex < ey) ? ex : ey;
        vx = vx << (ex - emin);
        vy = vy << (ey - emin);
        if (sx == sy) begin
            s = vx + vy; sr = sx;
        end else if (vx >= vy) begin
            s = vx - vy; sr = sx;
        end else begin
            s = vy - vx; sr = sy;
        end
        if (s == 320'd0) return 32'd0;
        p = 0;
        for (int i = 0; i < 320; i++) if (s[i]) p = i;
        e  = emin + p - 23;
        up = 1'b0;
        if (p > 23) begin
            m = 24'(s >> (p - 23));
`ifdef ALU2_ROUND_NEAREST_EN
            begin
                logic [319:0] rem, half;
                rem  = s & ((320'd1 << (p - 23)) - 320'd1);
                half = 320'd1 << (p - 24);
                up   = (rem > half) || ((rem == half) && m[0]);
            end
`endif
        end else begin
            m = 24'(s << (23 - p));
        end
        if (up) begin
            if (m == 24'hFFFFFF) begin
                m = 24'h800000;
                e = e + 1;
            end else begin
                m = m + 24'd1;
            end
        end
        if (e <= 0) return 32'd0;
        if (e >= 255) return {sr, 8'hFF, 23'd0};
        return {sr, 8'(e), m[22:0]};
    endfunction

    function automatic bit ref_cmp(input logic [2:0] op, input logic [31:0] x,
                                   input logic [31:0] y);
        logic [30:0] mx, my;
        bit          nx, ny, lt, eq;
        if (is_nan(x) || is_nan(y)) return 1'b0;
        mx = (x[30:23] == 8'd0) ? 31'd0 : x[30:0];
        my = (y[30:23] == 8'd0) ? 31'd0 : y[30:0];
        nx = (mx != 31'd0) && x[31];
        ny = (my != 31'd0) && y[31];
        eq = (mx == my) && (nx == ny);
        if (nx != ny)  lt = nx;
        else if (!nx)  lt = (mx < my);
        else           lt = (mx > my);
        case (op)
            3'b101:  return eq;
            3'b110:  return lt;
            3'b111:  return lt || eq;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_fp(input logic [7:0] near);
        int sel, e;
        sel = int'($urandom_range(0, 19));
        e   = int'(near) + int'($urandom_range(0, 60)) - 30;
        if (e < 1)   e = 1;
        if (e > 254) e = 254;
        case (sel)
            0:       return {1'($urandom), 31'd0};
            1:       return {1'($urandom), 8'hFF, 23'd0};
            2:       return {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
            3:       return {1'($urandom), 8'd0, 23'($urandom)};
            4:       return {1'($urandom), 8'hFE, 23'($urandom)};
            default: return {1'($urandom), 8'(e), 23'($urandom)};
        endcase
    endfunction

    // Called at a falling edge; drives start for one cycle and returns at the
    // falling edge of the done cycle, so consecutive calls are back-to-back.
    task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res);
        logic [31:0] exp_res;
        bit          arith;
        arith = (op == 3'b010) || (op == 3'b011);
        if (arith) begin
            exp_res = ref_add(x, y, op == 3'b011);
        end else if (op == 3'b101 || op == 3'b110 || op == 3'b111) begin
            exp_res = {31'd0, ref_cmp(op, x, y)};
            cc_exp  = exp_res[0];
        end else begin
            exp_res = x;
        end
        bus.start      = 1'b1;
        bus.ALUcontrol = op;
        bus.a          = x;
        bus.b          = y;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.a          = $urandom();
        bus.b          = $urandom();
        bus.ALUcontrol = 3'($urandom());
        if (arith) begin
            for (int k = 1; k <= 3; k++) begin
                chk($sformatf("busy N+%0d op%0d", k, op), {31'd0, bus.busy}, 32'd1);
                chk($sformatf("done N+%0d op%0d", k, op), {31'd0, bus.done}, 32'd0);
                @(negedge clk);
            end
        end
        chk($sformatf("done op%0d", op), {31'd0, bus.done}, 32'd1);
        chk($sformatf("busy at done op%0d", op), {31'd0, bus.busy}, 32'd0);
        chk($sformatf("result op%0d a=%h b=%h", op, x, y), bus.result, exp_res);
        chk($sformatf("cc op%0d a=%h b=%h", op, x, y), {31'd0, bus.cc}, {31'd0, cc_exp});
        res = bus.result;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.ALUcontrol = 3'd0;
        bus.a          = 32'd0;
        bus.b          = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset busy",   {31'd0, bus.busy}, 32'd0);
        chk("reset done",   {31'd0, bus.done}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset cc",     {31'd0, bus.cc}, 32'd0);
        rst = 1'b0;

        do_op(3'b010, 32'h3F800000, 32'h40000000, r);
        chk("add 1+2", r, 32'h40400000);
        do_op(3'b011, 32'h3FC00000, 32'h3FC00000, r);
        chk("sub cancel", r, 32'h00000000);
        do_op(3'b010, 32'h7F7FFFFF, 32'h7F7FFFFF, r);
        chk("add overflow", r, 32'h7F800000);
        do_op(3'b110, 32'h3F800000, 32'h40000000, r);
        chk("clt result", r, 32'h00000001);
        chk("clt cc", {31'd0, bus.cc}, 32'd1);
        do_op(3'b101, 32'h7FC00000, 32'h7FC00000, r);
        chk("ceq nan cc", {31'd0, bus.cc}, 32'd0);
        do_op(3'b010, 32'h3F800000, 32'h33C00000, r);
`ifdef ALU2_ROUND_NEAREST_EN
        chk("add round", r, 32'h3F800001);
`else
        chk("add round", r, 32'h3F800000);
`endif
        do_op(3'b100, 32'h7FA12345, 32'h0, r);
        chk("mov nan payload", r, 32'h7FA12345);
        do_op(3'b000, 32'hFF812345, 32'h0, r);
        do_op(3'b001, 32'h00000007, 32'h0, r);
        do_op(3'b101, 32'h00000000, 32'h80000000, r);
        chk("ceq +0 -0", r, 32'h00000001);
        do_op(3'b111, 32'h80000000, 32'h00000000, r);
        do_op(3'b110, 32'h3F800000, 32'h7FC00001, r);
        do_op(3'b010, 32'h7F800000, 32'hFF800000, r);
        chk("inf-inf", r, 32'h7FC00000);
        do_op(3'b010, 32'hFF800000, 32'h3F800000, r);
        chk("inf+fin", r, 32'hFF800000);
        do_op(3'b011, 32'h3F800000, 32'h7F800000, r);
        chk("fin-inf", r, 32'hFF800000);
        do_op(3'b010, 32'h00000001, 32'h3F800000, r);
        chk("denorm flush", r, 32'h3F800000);
        do_op(3'b011, 32'h00800001, 32'h00800000, r);
        chk("underflow", r, 32'h00000000);

        // start held high while busy must not disturb the add in flight
        bus.start = 1'b1; bus.ALUcontrol = 3'b010; bus.a = 32'h3F800000; bus.b = 32'h40000000;
        @(negedge clk);
        bus.ALUcontrol = 3'b100; bus.a = 32'h12345678; bus.b = 32'h0;
        chk("busy ign N+1", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("done ign N+2", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        chk("done ign N+3", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("done ign N+4",   {31'd0, bus.done}, 32'd1);
        chk("result ign N+4", bus.result, 32'h40400000);
        @(negedge clk);
        chk("no extra done",  {31'd0, bus.done}, 32'd0);
        chk("result held",    bus.result, 32'h40400000);

        // reset in the middle of an add
        do_op(3'b110, 32'h3F800000, 32'h40000000, r);
        bus.start = 1'b1; bus.ALUcontrol = 3'b010; bus.a = 32'h3F800000; bus.b = 32'h40000000;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        cc_exp = 1'b0;
        chk("rst busy",   {31'd0, bus.busy}, 32'd0);
        chk("rst done",   {31'd0, bus.done}, 32'd0);
        chk("rst result", bus.result, 32'd0);
        chk("rst cc",     {31'd0, bus.cc}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no done after rst", {31'd0, bus.done}, 32'd0);
        end
        // start while rst is high is ignored
        rst = 1'b1; bus.start = 1'b1; bus.ALUcontrol = 3'b100; bus.a = 32'h11111111;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        chk("start in rst done",   {31'd0, bus.done}, 32'd0);
        chk("start in rst result", bus.result, 32'd0);
        do_op(3'b100, 32'hDEADBEEF, 32'h0, r);
        chk("mov after rst", r, 32'hDEADBEEF);

        for (int i = 0; i < 400; i++) begin
            logic [2:0]  op;
            logic [31:0] x, y;
            op = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(2, 3)) : 3'($urandom_range(0, 7));
            x  = rand_fp(8'($urandom_range(1, 254)));
            y  = rand_fp(x[30:23]);
            case ($urandom_range(0, 9))
                0:       y = x;
                1:       y = x ^ 32'h80000000;
                default: ;
            endcase
            do_op(op, x, y, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
